// File: rtl/jesd204_up_pkg.sv
// Shared register offsets and IRQ state encoding for the JESD204 up_clk register slices.
package jesd204_up_pkg;

    localparam logic [5:0] OFF_ENABLE       = 6'h00;
    localparam logic [5:0] OFF_PENDING      = 6'h01;
    localparam logic [5:0] OFF_SOURCE       = 6'h02;
    localparam logic [5:0] OFF_MODE         = 6'h03;
    localparam logic [5:0] OFF_FORCE        = 6'h04;
    localparam logic [5:0] OFF_HOLDOFF      = 6'h05;
    localparam logic [5:0] OFF_STATE        = 6'h06;
    localparam logic [5:0] OFF_STAT_CTRL    = 6'h08;
    localparam logic [5:0] OFF_LINK_EN_CNT  = 6'h09;
    localparam logic [5:0] OFF_IRQ_CNT_BASE = 6'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } irq_state_t;

endpackage

// File: rtl/jesd204_up_sat_counter.sv
// Event counter that sticks at all-ones; a clear beats a coincident increment.
module jesd204_up_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/jesd204_up_irq_stats.sv
// Interrupt controller with edge/level sources, software force, hold-off coalescing
// and per-source saturating event statistics, in a 64-word register window.
module jesd204_up_irq_stats
    import jesd204_up_pkg::*;
#(
    parameter int          NUM_IRQS      = 8,
    parameter int          CNT_WIDTH     = 16,
    parameter int          HOLDOFF_WIDTH = 16,
    parameter logic [11:0] BASE_ADDR     = 12'h0c0,
    parameter int          ENABLE_STATS  = 1
) (
    input  logic                up_clk,
    input  logic                up_reset,
    input  logic                up_wreq,
    input  logic [11:0]         up_waddr,
    input  logic [31:0]         up_wdata,
    input  logic                up_rreq,
    input  logic [11:0]         up_raddr,
    output logic [31:0]         up_rdata,
    output logic                up_rack,
    input  logic [NUM_IRQS-1:0] up_irq_trigger,
    input  logic                up_link_enable,
    output logic                irq
);

    logic                     wr_hit, rd_hit;
    logic [5:0]               woff, roff;
    logic [NUM_IRQS-1:0]      wdata_irqs;
    logic [NUM_IRQS-1:0]      enable_reg, mode_reg, source_reg, trigger_d_reg;
    logic [NUM_IRQS-1:0]      ev, pending, set_bits, clr_bits, force_bits, source_next;
    logic [HOLDOFF_WIDTH-1:0] holdoff_reg, timer_reg, timer_next;
    irq_state_t               state_reg, state_next;
    logic                     irq_reg, link_d_reg, link_rise, stat_clr;
    logic [NUM_IRQS:0]        cnt_inc;
    logic [CNT_WIDTH-1:0]     cnt_all [NUM_IRQS+1];
    logic [31:0]              rd_word;
    logic                     unused_wdata;

    assign wr_hit       = up_wreq && (up_waddr[11:6] == BASE_ADDR[11:6]);
    assign rd_hit       = up_rreq && (up_raddr[11:6] == BASE_ADDR[11:6]);
    assign woff         = up_waddr[5:0];
    assign roff         = up_raddr[5:0];
    assign wdata_irqs   = up_wdata[NUM_IRQS-1:0];
    assign unused_wdata = ^up_wdata;

    // A set from an event or FORCE overrides a W1C landing in the same cycle.
    always_comb begin
        ev          = up_irq_trigger & ~trigger_d_reg;
        clr_bits    = (wr_hit && (woff == OFF_PENDING)) ? wdata_irqs : '0;
        force_bits  = (wr_hit && (woff == OFF_FORCE)) ? wdata_irqs : '0;
        set_bits    = (mode_reg & ev) | (~mode_reg & up_irq_trigger) | force_bits;
        source_next = (source_reg & ~clr_bits) | set_bits;
        pending     = source_reg & enable_reg;
    end

    always_ff @(posedge up_clk or posedge up_reset) begin
        if (up_reset) begin
            enable_reg    <= '0;
            mode_reg      <= '0;
            holdoff_reg   <= '0;
            source_reg    <= '0;
            trigger_d_reg <= '0;
            link_d_reg    <= 1'b0;
        end else begin
            source_reg    <= source_next;
            trigger_d_reg <= up_irq_trigger;
            link_d_reg    <= up_link_enable;
            if (wr_hit) begin
                case (woff)
                    OFF_ENABLE:  enable_reg  <= wdata_irqs;
                    OFF_MODE:    mode_reg    <= wdata_irqs;
                    OFF_HOLDOFF: holdoff_reg <= up_wdata[HOLDOFF_WIDTH-1:0];
                    default:     ;
                endcase
            end
        end
    end

    // The timer is only loaded on ASSERT->HOLDOFF, so later HOLDOFF writes
    // take effect on the next hold-off period.
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        case (state_reg)
            IDLE: begin
                if (|pending) state_next = ASSERT;
            end
            ASSERT: begin
                if (pending == '0) begin
                    if (holdoff_reg != '0) begin
                        state_next = HOLDOFF;
                        timer_next = holdoff_reg - HOLDOFF_WIDTH'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            HOLDOFF: begin
                if (timer_reg == '0) state_next = IDLE;
                else                 timer_next = timer_reg - HOLDOFF_WIDTH'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge up_clk or posedge up_reset) begin
        if (up_reset) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            irq_reg   <= (state_next == ASSERT);
        end
    end

    assign irq = irq_reg;

    // Counter slot NUM_IRQS is the link-enable counter.
    assign link_rise = up_link_enable & ~link_d_reg;
    assign stat_clr  = wr_hit && (woff == OFF_STAT_CTRL) && up_wdata[0];
    assign cnt_inc   = {link_rise, ev};

    generate
        if (ENABLE_STATS != 0) begin : g_stats
            for (genvar gi = 0; gi <= NUM_IRQS; gi++) begin : g_cnt
                jesd204_up_sat_counter #(
                    .WIDTH (CNT_WIDTH)
                ) u_cnt (
                    .clk   (up_clk),
                    .reset (up_reset),
                    .clr   (stat_clr),
                    .inc   (cnt_inc[gi]),
                    .count (cnt_all[gi])
                );
            end
        end else begin : g_no_stats
            for (genvar gi = 0; gi <= NUM_IRQS; gi++) begin : g_zero
                assign cnt_all[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        case (roff)
            OFF_ENABLE:      rd_word[NUM_IRQS-1:0]      = enable_reg;
            OFF_PENDING:     rd_word[NUM_IRQS-1:0]      = pending;
            OFF_SOURCE:      rd_word[NUM_IRQS-1:0]      = source_reg;
            OFF_MODE:        rd_word[NUM_IRQS-1:0]      = mode_reg;
            OFF_HOLDOFF:     rd_word[HOLDOFF_WIDTH-1:0] = holdoff_reg;
            OFF_STATE:       rd_word[1:0]               = state_reg;
            OFF_LINK_EN_CNT: rd_word[CNT_WIDTH-1:0]     = cnt_all[NUM_IRQS];
            default: begin
                for (int i = 0; i < NUM_IRQS; i++) begin
                    if (roff == (OFF_IRQ_CNT_BASE + 6'(i))) begin
                        rd_word[CNT_WIDTH-1:0] = cnt_all[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge up_clk or posedge up_reset) begin
        if (up_reset) begin
            up_rack  <= 1'b0;
            up_rdata <= '0;
        end else begin
            up_rack  <= rd_hit;
            up_rdata <= rd_hit ? rd_word : '0;
        end
    end

endmodule

// File: doc/jesd204_up_irq_stats.md
Name: jesd204_up_irq_stats

Overview:
Parametrised interrupt controller and event-statistics register slice for the JESD204 register map. It generalises the fixed IRQ block to up to 32 sources and adds:
- per-source edge/level mode
- a software force register
- an interrupt hold-off (coalescing) FSM
- per-source saturating event counters and a link-enable counter
It sits in the up_clk domain beside the common register map. Its read data is muxed into up_rdata by the parent.

Parameters:
NUM_IRQS, 8, number of interrupt sources (1..32)
CNT_WIDTH, 16, width of each event counter (1..32)
HOLDOFF_WIDTH, 16, width of hold-off timer (1..32)
BASE_ADDR, 12'h0c0, word base of the 64-word window; must be 64-aligned
ENABLE_STATS, 1, 0 removes counters; their reads return 0

Ports:
up_clk  input  1  register-map clock, the only clock
up_reset  input  1  asynchronous, active-high reset
up_wreq  input  1  write strobe, one cycle
up_waddr  input  12  write word address
up_wdata  input  32  write data
up_rreq  input  1  read strobe, one cycle
up_raddr  input  12  read word address
up_rdata  output  32  registered read data
up_rack  output  1  read acknowledge
up_irq_trigger  input  NUM_IRQS  per-source event inputs
up_link_enable  input  1  link enabled (active-low of core reset); each rising edge is counted
irq  output  1  interrupt line, registered

Behaviour:
- Decode: a hit is addr[11:6]==BASE_ADDR[11:6]; offset is addr[5:0]. Misses are ignored; a read miss returns up_rack=0 and up_rdata=0.
- Read: up_rack=1 and up_rdata valid exactly one cycle after up_rreq. Otherwise up_rack=0 and up_rdata=0. Unused bits read 0.
- Register map (offsets):
  - 0x00 ENABLE (rw)
  - 0x01 PENDING (= SOURCE & ENABLE; write-1-to-clear SOURCE)
  - 0x02 SOURCE (ro)
  - 0x03 MODE (rw; 1=edge, 0=level)
  - 0x04 FORCE (wo, reads 0; a 1 sets SOURCE bit)
  - 0x05 HOLDOFF (rw, cycles)
  - 0x06 STATE (ro; [1:0] FSM state)
  - 0x08 STAT_CTRL (wo; bit0=1 clears all counters)
  - 0x09 LINK_EN_CNT (ro)
  - 0x20+i IRQ_CNT[i] (ro, i<NUM_IRQS)
- Event: ev[i] = trigger[i] & ~trigger_d[i], where trigger_d is a registered copy.
- SOURCE set term:
  - edge mode: ev | force
  - level mode: trigger | force
  - SOURCE_next = (SOURCE & ~clr) | set. Set wins over a simultaneous W1C. In level mode a held trigger re-sets the bit the cycle after a clear.
- Counters:
  - IRQ_CNT[i] increments on ev[i] in both modes. FORCE does not count.
  - LINK_EN_CNT increments on each rising edge of up_link_enable.
  - All counters saturate at all-ones; no wrap.
  - A STAT_CTRL clear in the same cycle as an increment wins, so the counter reads 0.
- IRQ FSM:
  - IDLE (irq=0): |PENDING -> ASSERT.
  - ASSERT (irq=1): PENDING==0 -> HOLDOFF if HOLDOFF!=0, with timer loaded to HOLDOFF-1; else -> IDLE.
  - HOLDOFF (irq=0 regardless of PENDING): timer decrements each cycle; at timer==0 -> IDLE. Pending events are serviced on return to IDLE.
  - irq is registered from the state. Assertion latency is 2 cycles from trigger to irq in edge mode and 1 cycle from PENDING!=0.
  - Writing HOLDOFF mid-hold-off does not affect the running timer.
- Reset (async, up_reset=1), all cleared:
  - ENABLE, SOURCE, MODE, HOLDOFF = 0
  - all counters = 0
  - trigger_d = 0, up_link_enable_d = 0
  - FSM = IDLE
  - irq = 0, up_rack = 0, up_rdata = 0
- Writes to bits >= NUM_IRQS are ignored.
- With ENABLE_STATS=0 the counters, their registers and STAT_CTRL are absent and read 0.

Decomposition:
- Shared package jesd204_up_pkg holds:
  - offset constants: OFF_ENABLE … OFF_IRQ_CNT_BASE
  - FSM state encoding: IDLE=2'd0, ASSERT=2'd1, HOLDOFF=2'd2
- One sub-module, jesd204_up_sat_counter:
  - parameters: WIDTH
  - ports: clk, reset, clr, inc, count
  - saturating counter with clear-priority; instantiated NUM_IRQS+1 times under a generate.

Test Plan:
1. Reset, then read every offset -> all 0. up_rack pulses exactly 1 cycle after each up_rreq. A read of a BASE miss gives up_rack=0.
2. NUM_IRQS=8, MODE=0xFF, ENABLE=0x05, pulse trigger[0] -> SOURCE=0x01, irq=1 two cycles after the pulse. W1C 0x01 -> irq=0. IRQ_CNT[0]=1.
3. Level mode, trigger[2] held high, W1C 0x04 -> SOURCE bit 2 reads 1 again the next cycle. In the same-cycle set/clear case, set wins.
4. HOLDOFF=10; assert, then clear; new event during hold-off -> irq stays 0 for 10 cycles, then re-asserts 2 cycles later with STATE sequence 1,2,0,1.
5. CNT_WIDTH=4, 20 edges on trigger[1] -> IRQ_CNT[1]=15 (saturated). STAT_CTRL=1 coincident with an edge -> 0.
6. Toggle up_link_enable 3 times, assert up_reset mid-sequence -> count resets to 0 asynchronously, then counts subsequent edges from 0.
